// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster output bundle from the VGA timing generator to the pixel/colour
//   pipeline. The generator drives it through the master modport and the
//   consumer reads it through the slave modport.
//
//   Signals:
//     hsync, vsync        sync pulses, polarity set by the generator
//     de                  visible-area data enable
//     x, y                pixel column / line, zero outside the visible area
//     line_start          one-cycle strobe at h=0
//     frame_start         one-cycle strobe at h=0, v=0
//     vga_r/g/b           colour-bar outputs, only when VGA_TIMING_PATTERN_EN
//                         is defined
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int COUNT_WIDTH = 11
`ifdef VGA_TIMING_PATTERN_EN
    , parameter int COLOR_WIDTH = 4
`endif
);
    logic                   hsync;
    logic                   vsync;
    logic                   de;
    logic [COUNT_WIDTH-1:0] x;
    logic [COUNT_WIDTH-1:0] y;
    logic                   line_start;
    logic                   frame_start;
`ifdef VGA_TIMING_PATTERN_EN
    logic [COLOR_WIDTH-1:0] vga_r;
    logic [COLOR_WIDTH-1:0] vga_g;
    logic [COLOR_WIDTH-1:0] vga_b;
`endif

    modport master (
        output hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TIMING_PATTERN_EN
        , output vga_r, vga_g, vga_b
`endif
    );

    modport slave (
        input hsync, vsync, de, x, y, line_start, frame_start
`ifdef VGA_TIMING_PATTERN_EN
        , input vga_r, vga_g, vga_b
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal counter h_cnt
//   (0..H_TOTAL-1) and a vertical counter v_cnt (0..V_TOTAL-1) walk the
//   raster in the order visible, front porch, sync, back porch. Every output
//   is registered from the current counter value, so all outputs share one
//   cycle of latency and stay mutually aligned.
//
//   Ports:
//     clk_pixel   pixel clock
//     rst_n       asynchronous active-low reset
//     enable      counters and outputs advance only while high; strobes are
//                 forced low while it is low
//     vga         vga_timing_gen_if.master: hsync, vsync, de, x, y,
//                 line_start, frame_start (+ vga_r/g/b with the pattern)
//
//   Optional feature: define VGA_TIMING_PATTERN_EN to add an eight-bar
//   colour pattern (vga_r/g/b) for board bring-up. H_VISIBLE must then be a
//   multiple of 8.
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_VISIBLE       = 640,
    parameter int   H_FRONT_PORCH   = 16,
    parameter int   H_SYNC_WIDTH    = 96,
    parameter int   H_BACK_PORCH    = 48,
    parameter int   V_VISIBLE       = 480,
    parameter int   V_FRONT_PORCH   = 10,
    parameter int   V_SYNC_WIDTH    = 2,
    parameter int   V_BACK_PORCH    = 33,
    parameter logic H_SYNC_POLARITY = 1'b0,
    parameter logic V_SYNC_POLARITY = 1'b0,
    parameter int   COUNT_WIDTH     = 11
`ifdef VGA_TIMING_PATTERN_EN
    , parameter int COLOR_WIDTH     = 4
`endif
) (
    input  logic              clk_pixel,
    input  logic              rst_n,
    input  logic              enable,
    vga_timing_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [COUNT_WIDTH-1:0] H_LAST     = COUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] V_LAST     = COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] H_VIS      = COUNT_WIDTH'(H_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] V_VIS      = COUNT_WIDTH'(V_VISIBLE);
    localparam logic [COUNT_WIDTH-1:0] HS_START   = COUNT_WIDTH'(H_VISIBLE + H_FRONT_PORCH);
    localparam logic [COUNT_WIDTH-1:0] HS_STOP    = COUNT_WIDTH'(H_VISIBLE + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] VS_START   = COUNT_WIDTH'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [COUNT_WIDTH-1:0] VS_STOP    = COUNT_WIDTH'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_WIDTH);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

    // ---------------------------------------------------------------------
    // Raster counters
    // ---------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0] h_cnt_q, h_cnt_d;
    logic [COUNT_WIDTH-1:0] v_cnt_q, v_cnt_d;
    logic                   h_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (enable) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
            end else begin
                h_cnt_d = h_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Decode of the current count; registered below
    // ---------------------------------------------------------------------
    logic h_vis, v_vis, h_sync_act, v_sync_act;

    assign h_vis      = (h_cnt_q < H_VIS);
    assign v_vis      = (v_cnt_q < V_VIS);
    assign h_sync_act = (h_cnt_q >= HS_START) && (h_cnt_q < HS_STOP);
    assign v_sync_act = (v_cnt_q >= VS_START) && (v_cnt_q < VS_STOP);

    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   de_q, de_d;
    logic [COUNT_WIDTH-1:0] x_q, x_d;
    logic [COUNT_WIDTH-1:0] y_q, y_d;
    logic                   line_start_q, line_start_d;
    logic                   frame_start_q, frame_start_d;

    // While stalled every level output holds, which stretches an in-flight
    // sync pulse instead of truncating it. Strobes drop to 0 so a stall on
    // h=0 cannot repeat them.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (enable) begin
            hsync_d       = h_sync_act ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
            vsync_d       = v_sync_act ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
            de_d          = h_vis && v_vis;
            x_d           = (h_vis && v_vis) ? h_cnt_q : '0;
            y_d           = (h_vis && v_vis) ? v_cnt_q : '0;
            line_start_d  = (h_cnt_q == '0);
            frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~H_SYNC_POLARITY;
            vsync_q       <= ~V_SYNC_POLARITY;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.de          = de_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_TIMING_PATTERN_EN
    // ---------------------------------------------------------------------
    // Colour bars. seg_cnt counts pixels inside the current bar and bar_idx
    // selects the bar; both track h_cnt_q and clear when the line wraps, so
    // no divider is needed. bar_idx wrapping past 7 in the blanking region
    // is harmless because rgb is gated by de.
    // ---------------------------------------------------------------------
    localparam int BAR_W = H_VISIBLE / 8;
    localparam logic [COUNT_WIDTH-1:0] BAR_LAST = COUNT_WIDTH'(BAR_W - 1);

    logic [COUNT_WIDTH-1:0] seg_cnt_q, seg_cnt_d;
    logic [2:0]             bar_idx_q, bar_idx_d;
    logic [COLOR_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    always_comb begin
        seg_cnt_d = seg_cnt_q;
        bar_idx_d = bar_idx_q;
        if (enable) begin
            if (h_wrap) begin
                seg_cnt_d = '0;
                bar_idx_d = '0;
            end else if (seg_cnt_q == BAR_LAST) begin
                seg_cnt_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                seg_cnt_d = seg_cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
        if (enable) begin
            r_d = (h_vis && v_vis && bar_idx_q[2]) ? '1 : '0;
            g_d = (h_vis && v_vis && bar_idx_q[1]) ? '1 : '0;
            b_d = (h_vis && v_vis && bar_idx_q[0]) ? '1 : '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            seg_cnt_q <= '0;
            bar_idx_q <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
        end else begin
            seg_cnt_q <= seg_cnt_d;
            bar_idx_q <= bar_idx_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
        end
    end

    assign vga.vga_r = r_q;
    assign vga.vga_g = g_q;
    assign vga.vga_b = b_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboarded bench for vga_timing_gen with a reduced raster:
//   H: 16 visible, 2 front, 3 sync, 3 back  -> 24 per line
//   V:  4 visible, 1 front, 2 sync, 1 back  ->  8 lines, 192 per frame
//   The driver pushes the expected output word for every clock it issues;
//   a monitor pops and compares one cycle later. Directed measurements
//   (counts, periods, run lengths, async reset) use hand-derived constants.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
    localparam int HV = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VV = 4,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = 24, VT = 8;
    localparam int CW = 11;
`ifdef VGA_TIMING_PATTERN_EN
    localparam int CLW = 4;
`endif

    logic clk_pixel = 1'b0;
    logic rst_n     = 1'b0;
    logic enable    = 1'b0;

    vga_timing_gen_if #(.COUNT_WIDTH(CW)
`ifdef VGA_TIMING_PATTERN_EN
        , .COLOR_WIDTH(CLW)
`endif
    ) vga_bus ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .V_VISIBLE(VV), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
        .H_SYNC_POLARITY(1'b0), .V_SYNC_POLARITY(1'b0), .COUNT_WIDTH(CW)
`ifdef VGA_TIMING_PATTERN_EN
        , .COLOR_WIDTH(CLW)
`endif
    ) dut (
        .clk_pixel (clk_pixel),
        .rst_n     (rst_n),
        .enable    (enable),
        .vga       (vga_bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic          hs, vs, de;
        logic [CW-1:0] x, y;
        logic          ls, fs;
        logic [3:0]    r, g, b;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for a counter value, straight from the raster rules.
    function automatic exp_t spec_out(input int h, input int v);
        exp_t e;
        int   bar;
        e    = '0;
        e.hs = (h >= HV + HFP && h < HV + HFP + HSW) ? 1'b0 : 1'b1;
        e.vs = (v >= VV + VFP && v < VV + VFP + VSW) ? 1'b0 : 1'b1;
        e.de = (h < HV) && (v < VV);
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        if (e.de) begin
            e.x = CW'(h);
            e.y = CW'(v);
            bar = h / (HV / 8);
            e.r = ((bar & 4) != 0) ? 4'hF : 4'h0;
            e.g = ((bar & 2) != 0) ? 4'hF : 4'h0;
            e.b = ((bar & 1) != 0) ? 4'hF : 4'h0;
        end
        return e;
    endfunction

    function automatic exp_t reset_out();
        exp_t e;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        return e;
    endfunction

    // Monitor: compares one queued word per clock edge that was issued.
    initial begin
        exp_t me;
        forever begin
            @(posedge clk_pixel);
            #1;
            if (q.size() > 0) begin
                me = q.pop_front();
                check("hsync",       vga_bus.hsync,       me.hs);
                check("vsync",       vga_bus.vsync,       me.vs);
                check("de",          vga_bus.de,          me.de);
                check("x",           vga_bus.x,           me.x);
                check("y",           vga_bus.y,           me.y);
                check("line_start",  vga_bus.line_start,  me.ls);
                check("frame_start", vga_bus.frame_start, me.fs);
`ifdef VGA_TIMING_PATTERN_EN
                check("vga_r", vga_bus.vga_r, me.r);
                check("vga_g", vga_bus.vga_g, me.g);
                check("vga_b", vga_bus.vga_b, me.b);
`endif
            end
        end
    end

    // Driver-side reference state and negedge measurements.
    int   mh = 0, mv = 0;
    exp_t last;
    logic s_hs, s_vs, s_de, s_ls, s_fs;
    logic [CW-1:0] s_x, s_y;
    logic p_hs = 1'b1, p_vs = 1'b1;
    int   si = 0, last_ls = 0, last_fs = 0, ls_period = 0, fs_period = 0;
    int   hs_run = 0, hs_last_run = 0, hs_start_off = 0, vs_start_off = 0;
    bit   meas = 0;
    int   de_cnt = 0, hs_low = 0, vs_low = 0, ls_cnt = 0, fs_cnt = 0;

    task automatic sample();
        s_hs = vga_bus.hsync; s_vs = vga_bus.vsync; s_de = vga_bus.de;
        s_x  = vga_bus.x;     s_y  = vga_bus.y;
        s_ls = vga_bus.line_start; s_fs = vga_bus.frame_start;
        si++;
        if (meas) begin
            de_cnt += int'(s_de);
            hs_low += int'(!s_hs);
            vs_low += int'(!s_vs);
            ls_cnt += int'(s_ls);
            fs_cnt += int'(s_fs);
        end
        if (s_ls) begin ls_period = si - last_ls; last_ls = si; end
        if (s_fs) begin fs_period = si - last_fs; last_fs = si; end
        if (p_hs && !s_hs) hs_start_off = si - last_ls;
        if (p_vs && !s_vs) vs_start_off = si - last_fs;
        if (!s_hs) hs_run++;
        else if (hs_run > 0) begin hs_last_run = hs_run; hs_run = 0; end
        p_hs = s_hs;
        p_vs = s_vs;
    endtask

    task automatic step(input logic en);
        exp_t e;
        @(negedge clk_pixel);
        sample();
        enable = en;
        if (en) begin
            e = spec_out(mh, mv);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            e    = last;
            e.ls = 1'b0;
            e.fs = 1'b0;
        end
        last = e;
        q.push_back(e);
    endtask

    task automatic check_reset_now(input string tag);
        check({tag, "_hsync"}, vga_bus.hsync, 1);
        check({tag, "_vsync"}, vga_bus.vsync, 1);
        check({tag, "_de"},    vga_bus.de, 0);
        check({tag, "_x"},     vga_bus.x, 0);
        check({tag, "_y"},     vga_bus.y, 0);
        check({tag, "_ls"},    vga_bus.line_start, 0);
        check({tag, "_fs"},    vga_bus.frame_start, 0);
    endtask

    task automatic check_first_out(input string tag);
        check({tag, "_de"}, s_de, 1);
        check({tag, "_x"},  s_x, 0);
        check({tag, "_y"},  s_y, 0);
        check({tag, "_ls"}, s_ls, 1);
        check({tag, "_fs"}, s_fs, 1);
        check({tag, "_hs"}, s_hs, 1);
        check({tag, "_vs"}, s_vs, 1);
    endtask

    initial begin
        int guard;
        last = reset_out();

        // Reset hold
        repeat (3) @(negedge clk_pixel);
        check_reset_now("reset");
        @(negedge clk_pixel);
        rst_n = 1'b1;

        // First output after release reflects count 0,0
        step(1); step(1);
        check_first_out("first");

        // One full frame of counts
        meas = 1; de_cnt = 0; hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        repeat (192) step(1);
        meas = 0;
        check("frame_de_cycles",  de_cnt, 64);
        check("frame_hs_low",     hs_low, 24);
        check("frame_vs_low",     vs_low, 48);
        check("frame_line_starts", ls_cnt, 8);
        check("frame_frame_starts", fs_cnt, 1);
        check("vsync_start_offset", vs_start_off, 120);

        repeat (192) step(1);
        check("frame_period",  fs_period, 192);
        check("line_period",   ls_period, 24);
        check("hsync_width",   hs_last_run, 3);
        check("hsync_start_offset", hs_start_off, 18);

        // Stall for 5 cycles two cycles into hsync
        guard = 0;
        while (mh != 20 && guard < 100) begin step(1); guard++; end
        check("stall_reached", guard < 100, 1);
        repeat (5) step(0);
        repeat (12) step(1);
        check("stall_hsync_width", hs_last_run, 8);
        check("stall_line_period", ls_period, 29);

        repeat (30) step(1);

        // Async reset mid-frame at x=10, y=2
        guard = 0;
        while (!(mh == 10 && mv == 2) && guard < 400) begin step(1); guard++; end
        check("midreset_reached", guard < 400, 1);
        @(posedge clk_pixel);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_now("async_reset");
        mh = 0; mv = 0; last = reset_out();
        @(negedge clk_pixel);
        enable = 1'b0;
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        rst_n = 1'b1;
        step(1); step(1);
        check_first_out("restart");

        repeat (60) step(1);

        @(posedge clk_pixel);
        #2;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
